// File: rtl/sd_sector_reader_if.sv
// CPU-side bus of the sector reader: request, status flags and buffer read port.
interface sd_sector_reader_if;
    logic [31:0] sector;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [9:0]  byte_count;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_data;

    modport master (
        output sector, start, buf_addr,
        input  busy, done, error, byte_count, buf_data
    );

    modport slave (
        input  sector, start, buf_addr,
        output busy, done, error, byte_count, buf_data
    );
endinterface

// File: rtl/sd_sector_reader.sv
// Drives sd_controller through one 512-byte sector read and captures the bytes into a
// 512x8 buffer that the CPU reads back through a registered random-access port.
module sd_sector_reader #(
    parameter bit          BLOCK_ADDR     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned TW             = 26
) (
    input  logic              clk,
    input  logic              reset,
    sd_sector_reader_if.slave bus,
    input  logic              sd_ready,
    output logic              sd_rd,
    output logic [31:0]       sd_address,
    input  logic [7:0]        sd_dout,
    input  logic              sd_byte_available
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitRdy,
        StIssue,
        StWaitAcc,
        StRecv,
        StFin,
        StErr
    } state_e;

    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic          avail_q;
    logic [9:0]    count_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic          rd_q;
    logic [31:0]   addr_q;
    logic [7:0]    rdata_q;
    logic [7:0]    mem [512];

    logic byte_edge;
    logic full;
    logic timeout;
    logic capture;

    always_comb begin
        byte_edge = sd_byte_available & ~avail_q;
        full      = (count_q == 10'd512);
        timeout   = (timer_q == TimerLast);
        // Bytes past the 512th are dropped; reset blocks a write on the aborting edge.
        capture   = (state_q == StRecv) && byte_edge && !full && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            avail_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            avail_q <= sd_byte_available;
            rd_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        addr_q  <= BLOCK_ADDR ? bus.sector : {bus.sector[22:0], 9'd0};
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        count_q <= '0;
                        timer_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StWaitRdy;
                    end
                end
                StWaitRdy: begin
                    if (sd_ready) begin
                        rd_q    <= 1'b1;
                        state_q <= StIssue;
                    end else if (timeout) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StErr;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StIssue: begin
                    timer_q <= '0;
                    state_q <= StWaitAcc;
                end
                StWaitAcc: begin
                    if (!sd_ready) begin
                        timer_q <= '0;
                        state_q <= StRecv;
                    end else if (timeout) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StErr;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StRecv: begin
                    // The full check sees the registered count, so the last capture lands first.
                    if (full && sd_ready) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StFin;
                    end else if (capture) begin
                        count_q <= count_q + 10'd1;
                        timer_q <= '0;
                    end else if (timeout) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StErr;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StFin, StErr: state_q <= StIdle;
                default:      state_q <= StIdle;
            endcase
        end
    end

    // Write port only; contents survive reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[count_q[8:0]] <= sd_dout;
        end
    end

    // Read-before-write on an address collision, matching a simple dual-port BRAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[bus.buf_addr];
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.byte_count = count_q;
    assign bus.buf_data   = rdata_q;
    assign sd_rd          = rd_q;
    assign sd_address     = addr_q;

endmodule

// File: tb/tb_sd_sector_reader.sv
// Bench for sd_sector_reader: an SDHC instance driven by a byte-pacing sd_controller model
// with a scoreboard of emitted bytes, and an SDSC instance whose controller never goes ready.
module tb_sd_sector_reader;

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic reset;

    sd_sector_reader_if bus_a ();
    sd_sector_reader_if bus_b ();

    logic        rdy_a, rd_a, avail_a;
    logic [31:0] addr_a;
    logic [7:0]  dout_a;
    logic        rdy_b, rd_b, avail_b;
    logic [31:0] addr_b;
    logic [7:0]  dout_b;

    sd_sector_reader #(.BLOCK_ADDR(1'b1), .TIMEOUT_CYCLES(100), .TW(8)) dut_a (
        .clk               (CLOCK_50),
        .reset             (reset),
        .bus               (bus_a.slave),
        .sd_ready          (rdy_a),
        .sd_rd             (rd_a),
        .sd_address        (addr_a),
        .sd_dout           (dout_a),
        .sd_byte_available (avail_a)
    );

    sd_sector_reader #(.BLOCK_ADDR(1'b0), .TIMEOUT_CYCLES(100), .TW(8)) dut_b (
        .clk               (CLOCK_50),
        .reset             (reset),
        .bus               (bus_b.slave),
        .sd_ready          (rdy_b),
        .sd_rd             (rd_b),
        .sd_address        (addr_b),
        .sd_dout           (dout_b),
        .sd_byte_available (avail_b)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         model_n    = 0;
    int         model_tail = 4;
    logic [7:0] model_seed = 8'h00;
    bit         model_push = 1'b0;
    int         rd_pulses  = 0;

    // sd_controller model for instance A: acts on negedges, one sector per sd_rd pulse.
    initial begin
        rdy_a   = 1'b1;
        avail_a = 1'b0;
        dout_a  = '0;
        forever begin
            @(negedge CLOCK_50);
            if (rd_a === 1'b1) begin
                rd_pulses++;
                rdy_a = 1'b0;
                for (int i = 0; i < model_n; i++) begin
                    repeat (6) @(negedge CLOCK_50);
                    dout_a  = model_seed + 8'(i);
                    avail_a = 1'b1;
                    if (model_push) exp_q.push_back(dout_a);
                    repeat (2) @(negedge CLOCK_50);
                    avail_a = 1'b0;
                end
                repeat (model_tail) @(negedge CLOCK_50);
                rdy_a = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        n_tests++;
        if ({bus_a.busy, bus_a.done, bus_a.error, rd_a} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags_a: got %b want 0000",
                     {bus_a.busy, bus_a.done, bus_a.error, rd_a});
        end
        n_tests++;
        if ({bus_a.byte_count, addr_a, bus_a.buf_data} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_regs_a: count %0d addr %h data %h want all 0",
                     bus_a.byte_count, addr_a, bus_a.buf_data);
        end
        n_tests++;
        if ({bus_b.busy, bus_b.error, rd_b, addr_b} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_b: busy %b err %b rd %b addr %h want 0",
                     bus_b.busy, bus_b.error, rd_b, addr_b);
        end
        reset = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic test_sdhc_read;
        int         rd0;
        bit         ok;
        logic [7:0] exp;
        exp_q.delete();
        model_n = 512; model_tail = 4; model_seed = 8'h00; model_push = 1'b1;
        rd0 = rd_pulses;
        bus_a.sector = 32'h0000_0005;
        bus_a.start  = 1'b1;
        @(negedge CLOCK_50);
        bus_a.start  = 1'b0;
        n_tests++;
        if ({bus_a.busy, rd_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL start_cycle0: busy,sd_rd got %b want 10", {bus_a.busy, rd_a});
        end
        @(negedge CLOCK_50);
        n_tests++;
        if (rd_a !== 1'b1) begin
            n_fail++;
            $display("FAIL sd_rd_latency: got %b want 1 two cycles after start", rd_a);
        end
        @(negedge CLOCK_50);
        n_tests++;
        if (rd_a !== 1'b0) begin
            n_fail++;
            $display("FAIL sd_rd_width: got %b want 0 after one cycle", rd_a);
        end
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (bus_a.done || bus_a.error) begin ok = 1'b1; break; end
            @(negedge CLOCK_50);
        end
        n_tests++;
        if (!ok || {bus_a.done, bus_a.error, bus_a.busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL sdhc_done: done,err,busy got %b want 100 (finished %0b)",
                     {bus_a.done, bus_a.error, bus_a.busy}, ok);
        end
        n_tests++;
        if (addr_a !== 32'h0000_0005) begin
            n_fail++;
            $display("FAIL sdhc_address: got %h want 00000005", addr_a);
        end
        n_tests++;
        if (rd_pulses - rd0 !== 1) begin
            n_fail++;
            $display("FAIL sdhc_rd_pulses: got %0d want 1", rd_pulses - rd0);
        end
        n_tests++;
        if (bus_a.byte_count !== 10'd512) begin
            n_fail++;
            $display("FAIL sdhc_count: got %0d want 512", bus_a.byte_count);
        end
        for (int a = 0; a < 512; a++) begin
            bus_a.buf_addr = 9'(a);
            @(negedge CLOCK_50);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_tests++;
            if (bus_a.buf_data !== exp) begin
                n_fail++;
                $display("FAIL sdhc_buf[%0d]: got %h want %h", a, bus_a.buf_data, exp);
            end
        end
        bus_a.buf_addr = 9'h1FF;
        @(negedge CLOCK_50);
        n_tests++;
        if (bus_a.buf_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL buf_1ff: got %h want ff", bus_a.buf_data);
        end
    endtask

    task automatic test_sdsc_ready_low;
        logic rd_seen;
        rd_seen = 1'b0;
        bus_b.sector = 32'd3;
        bus_b.start  = 1'b1;
        @(negedge CLOCK_50);
        bus_b.start  = 1'b0;
        n_tests++;
        if (addr_b !== 32'h0000_0600 || bus_b.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sdsc_address: addr %h busy %b want 00000600 1", addr_b, bus_b.busy);
        end
        repeat (99) begin
            @(negedge CLOCK_50);
            rd_seen |= rd_b;
        end
        n_tests++;
        if ({bus_b.error, bus_b.busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL rdy_low_early: err,busy got %b want 01 at cycle 99",
                     {bus_b.error, bus_b.busy});
        end
        @(negedge CLOCK_50);
        rd_seen |= rd_b;
        n_tests++;
        if ({bus_b.error, bus_b.done, bus_b.busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL rdy_low_timeout: err,done,busy got %b want 100 at cycle 100",
                     {bus_b.error, bus_b.done, bus_b.busy});
        end
        n_tests++;
        if (rd_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_low_no_rd: sd_rd seen %b want 0", rd_seen);
        end
    endtask

    task automatic test_stall_timeout;
        int         since;
        bit         ok;
        logic [7:0] exp;
        exp_q.delete();
        model_n = 10; model_tail = 300; model_seed = 8'h80; model_push = 1'b1;
        bus_a.sector = 32'd7;
        bus_a.start  = 1'b1;
        @(negedge CLOCK_50);
        bus_a.start  = 1'b0;
        since = -1;
        ok    = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLOCK_50);
            if (since >= 0) since++;
            else if (bus_a.byte_count == 10'd10) since = 0;
            if (bus_a.done || bus_a.error) begin ok = 1'b1; break; end
        end
        n_tests++;
        if (!ok || {bus_a.error, bus_a.done, bus_a.busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL stall_error: err,done,busy got %b want 100 (finished %0b)",
                     {bus_a.error, bus_a.done, bus_a.busy}, ok);
        end
        n_tests++;
        if (bus_a.byte_count !== 10'd10) begin
            n_fail++;
            $display("FAIL stall_count: got %0d want 10", bus_a.byte_count);
        end
        n_tests++;
        if (since !== 100) begin
            n_fail++;
            $display("FAIL stall_latency: error %0d cycles after byte 10, want 100", since);
        end
        for (int a = 0; a < 10; a++) begin
            bus_a.buf_addr = 9'(a);
            @(negedge CLOCK_50);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_tests++;
            if (bus_a.buf_data !== exp) begin
                n_fail++;
                $display("FAIL stall_buf[%0d]: got %h want %h", a, bus_a.buf_data, exp);
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (rdy_a === 1'b1) begin ok = 1'b1; break; end
            @(negedge CLOCK_50);
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_model_release: sd_ready got %b want 1", rdy_a);
        end
    endtask

    task automatic test_start_while_busy;
        int         rd0;
        bit         ok;
        logic [7:0] exp;
        exp_q.delete();
        model_n = 512; model_tail = 4; model_seed = 8'h40; model_push = 1'b1;
        rd0 = rd_pulses;
        bus_a.sector = 32'h11;
        bus_a.start  = 1'b1;
        @(negedge CLOCK_50);
        bus_a.start  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (bus_a.byte_count >= 10'd20) begin ok = 1'b1; break; end
            @(negedge CLOCK_50);
        end
        bus_a.sector = 32'h99;
        bus_a.start  = 1'b1;
        @(negedge CLOCK_50);
        bus_a.start  = 1'b0;
        n_tests++;
        if (!ok || bus_a.busy !== 1'b1 || addr_a !== 32'h11) begin
            n_fail++;
            $display("FAIL busy_start_ignored: busy %b addr %h want 1 00000011 (reached %0b)",
                     bus_a.busy, addr_a, ok);
        end
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (bus_a.done || bus_a.error) begin ok = 1'b1; break; end
            @(negedge CLOCK_50);
        end
        n_tests++;
        if (!ok || bus_a.done !== 1'b1 || bus_a.byte_count !== 10'd512 || addr_a !== 32'h11) begin
            n_fail++;
            $display("FAIL busy_complete: done %b count %0d addr %h want 1 512 00000011",
                     bus_a.done, bus_a.byte_count, addr_a);
        end
        n_tests++;
        if (rd_pulses - rd0 !== 1) begin
            n_fail++;
            $display("FAIL busy_rd_pulses: got %0d want 1", rd_pulses - rd0);
        end
        for (int a = 0; a < 512; a++) begin
            bus_a.buf_addr = 9'(a);
            @(negedge CLOCK_50);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_tests++;
            if (bus_a.buf_data !== exp) begin
                n_fail++;
                $display("FAIL busy_buf[%0d]: got %h want %h", a, bus_a.buf_data, exp);
            end
        end
        // Leave a fresh read in flight for the reset test.
        model_n = 512; model_tail = 4; model_seed = 8'h00; model_push = 1'b0;
        bus_a.sector = 32'h22;
        bus_a.start  = 1'b1;
        @(negedge CLOCK_50);
        bus_a.start  = 1'b0;
        n_tests++;
        if ({bus_a.done, bus_a.busy} !== 2'b01 || addr_a !== 32'h22) begin
            n_fail++;
            $display("FAIL restart_clears_done: done,busy %b addr %h want 01 00000022",
                     {bus_a.done, bus_a.busy}, addr_a);
        end
    endtask

    task automatic test_reset_mid_recv;
        bit       ok;
        logic [9:0] max_count;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (bus_a.byte_count == 10'd200) begin ok = 1'b1; break; end
            @(negedge CLOCK_50);
        end
        reset = 1'b1;
        @(negedge CLOCK_50);
        n_tests++;
        if (!ok || {bus_a.busy, bus_a.done, bus_a.error, rd_a} !== 4'b0000
            || bus_a.byte_count !== 10'd0) begin
            n_fail++;
            $display("FAIL mid_reset: busy,done,err,rd %b count %0d want 0000 0 (reached %0b)",
                     {bus_a.busy, bus_a.done, bus_a.error, rd_a}, bus_a.byte_count, ok);
        end
        reset = 1'b0;
        max_count = '0;
        repeat (300) begin
            @(negedge CLOCK_50);
            if (bus_a.byte_count > max_count) max_count = bus_a.byte_count;
        end
        n_tests++;
        if (max_count !== 10'd0 || bus_a.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_trailing_capture: max count %0d busy %b want 0 0",
                     max_count, bus_a.busy);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus_a.start    = 1'b0;
        bus_a.sector   = '0;
        bus_a.buf_addr = '0;
        bus_b.start    = 1'b0;
        bus_b.sector   = '0;
        bus_b.buf_addr = '0;
        rdy_b          = 1'b0;
        avail_b        = 1'b0;
        dout_b         = '0;
        @(negedge CLOCK_50);
        test_reset();
        test_sdhc_read();
        test_sdsc_ready_low();
        test_stall_timeout();
        test_start_while_busy();
        test_reset_mid_recv();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_sector_reader.md
Name: sd_sector_reader

Overview:
- Sequences the SPI-mode SD controller to read one 512-byte sector and captures the bytes into an internal 512x8 buffer.
- The CPU bus side writes a sector number, pulses start, polls busy/done/error, then reads buffered bytes at random through a 1-cycle-latency read port.
- Replaces direct CPU polling of byte_available with a hardware-paced capture.
- Sits between the bus address decoder and sd_controller, in the CLOCK_50 domain.

Parameters:
- BLOCK_ADDR, 1, 1 = card is SDHC/SDXC, so sd_address = sector; 0 = SDSC, so sd_address = sector<<9 (truncated to 32 bits).
- TIMEOUT_CYCLES, 50000000, cycles allowed for each wait phase (ready, accept, and each byte) before error is flagged.
- TW, 26, width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk, in, 1: system clock; all logic on rising edge.
- reset, in, 1: synchronous, active-high reset.
- sector, in, 32: sector number; sampled on the start cycle.
- start, in, 1: single-cycle request pulse; ignored while busy=1.
- busy, out, 1: high from the cycle after an accepted start until done or error is asserted.
- done, out, 1: sticky success flag; cleared by an accepted start or by reset.
- error, out, 1: sticky timeout flag; cleared by an accepted start or by reset.
- byte_count, out, 10: number of bytes captured so far in the current read (0..512).
- buf_addr, in, 9: CPU read address into the buffer.
- buf_data, out, 8: Buffer[buf_addr] registered, 1 cycle after buf_addr is presented.
- sd_ready, in, 1: from sd_controller; high when the controller is idle.
- sd_rd, out, 1: read-command pulse to sd_controller.
- sd_address, out, 32: address to sd_controller; held stable from ISSUE until the FSM returns to IDLE.
- sd_dout, in, 8: data byte from sd_controller.
- sd_byte_available, in, 1: level signal from sd_controller, high while sd_dout is valid.

Behaviour:
- Reset values:
  - state IDLE; busy, done, error, sd_rd = 0; byte_count = 0; sd_address = 0; buf_data = 0.
  - Buffer contents are not cleared.
- A reset asserted mid-operation aborts the read immediately, with the same values as above. Any in-flight sd_controller transfer continues independently; its bytes are ignored.
- FSM states:
  - IDLE: on start=1, latch sd_address from sector per BLOCK_ADDR, clear done/error/byte_count/timer, set busy, go to WAIT_RDY.
  - WAIT_RDY: once sd_ready=1, go to ISSUE. If the timer reaches TIMEOUT_CYCLES, go to ERR.
  - ISSUE: drive sd_rd=1 for exactly one cycle, clear the timer, go to WAIT_ACC.
  - WAIT_ACC: once sd_ready=0 (controller accepted the command), clear the timer and go to RECV. On timeout, go to ERR.
  - RECV:
    - A byte is captured on the rising edge of sd_byte_available, detected against a registered previous value.
    - On each capture: Buffer[byte_count[8:0]] <= sd_dout, byte_count += 1, timer cleared.
    - When byte_count==512 and sd_ready=1, go to FIN.
    - Bytes beyond 512 are discarded and byte_count saturates at 512.
    - On timeout (no byte, or ready not returning), go to ERR.
  - FIN: done=1, busy=0, go to IDLE.
  - ERR: error=1, busy=0, go to IDLE. Bytes captured before the timeout remain in the buffer.
- Timer:
  - Increments every cycle in WAIT_RDY, WAIT_ACC and RECV.
  - Compared with ==TIMEOUT_CYCLES-1, so timeout fires after TIMEOUT_CYCLES cycles.
- Latency: start to sd_rd takes a minimum of 2 cycles (IDLE->WAIT_RDY->ISSUE).
- Edge cases:
  - A byte edge and the 512 count in the same cycle: the byte is captured first; the FIN check uses the updated count on the next cycle.
  - Simultaneous start and busy=1: start is ignored, with no flag change.
  - A start in the same cycle that FIN/ERR sets its flag is also ignored; it is accepted only in IDLE.
- Buffer port:
  - Buffer writes occur only in RECV.
  - The read port is independent. A read and a write at the same address in the same cycle returns the old data (read-before-write). This maps to a simple dual-port BRAM.
- Width rules: byte_count is 10 bits; the buffer index uses byte_count[8:0]; SDSC shift is {sector[22:0], 9'd0}.

Test Plan:
- Normal SDHC read: reset, sector=0x00000005 with BLOCK_ADDR=1, start pulse, model returns bytes i&0xFF at 8-cycle spacing -> sd_address=0x5, one sd_rd pulse, byte_count=512, done=1, busy=0, buf_addr=0x1FF gives 0xFF one cycle later.
- SDSC addressing: BLOCK_ADDR=0, sector=3 -> sd_address=0x00000600.
- Stall timeout: TIMEOUT_CYCLES=100, model stops after 10 bytes -> error=1 at ~100 cycles after byte 10, byte_count=10, done=0, Buffer[0..9] intact.
- sd_ready held low from start: TIMEOUT_CYCLES=100 -> no sd_rd pulse, error=1 exactly 100 cycles after entering WAIT_RDY.
- Start while busy: second start during RECV -> ignored; the transfer completes with the original sector, and a new start afterwards clears done.
- Reset mid-RECV at byte 200: -> next cycle busy=0, done=0, error=0, byte_count=0, sd_rd=0; trailing byte edges are not captured.
